grey_scan_ctrl: RTL and testbench

//  Sequencer for the 12-digit grey/BCD event counter's digit-select mux.
//  On request, walks the counter's select input over every digit and captures a

---
 rtl/grey_scan_pkg.sv | 25 ++
 rtl/grey_scan_if.sv | 24 ++
 rtl/grey_scan_buf.sv | 31 +++
 rtl/grey_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_grey_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grey_scan_pkg.sv
// grey_scan_pkg: shared state type and constants for the digit-scan sequencer.
// Optional feature macro: GREY_SCAN_LZB_EN (leading-zero blanking).
package grey_scan_pkg;

   localparam int NDIG_DEF   = 12;
   localparam int SETTLE_DEF = 2;
   localparam int SELW_DEF   = 6;

   localparam logic [3:0] BLANK  = 4'hF;
   localparam logic [3:0] MAXDIG = 4'd9;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      CAP,
      OUT,
      DONE
   } state_t;

   // A captured byte is only a legal digit if it is BCD with a clear high nibble.
   function automatic logic bad_digit(input logic [7:0] c);
      return (c[3:0] > MAXDIG) || (c[7:4] != 4'h0);
   endfunction

endpackage

// File: rtl/grey_scan_if.sv
// grey_scan_if: valid/ready digit stream from the sequencer to the output stage.
// Signal names match the sequencer's pad-facing port names.
interface grey_scan_if;

   logic       o_valid;
   logic       i_ready;
   logic [3:0] o_digit;
   logic [3:0] o_pos;

   modport master (
      output o_valid,
      output o_digit,
      output o_pos,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_digit,
      input  o_pos,
      output i_ready
   );

endinterface

// File: rtl/grey_scan_buf.sv
// grey_scan_buf: NDIG x 4 snapshot register file.
// One write port at the capture index, one async read port at the stream position.
module grey_scan_buf
   import grey_scan_pkg::*;
#(
   parameter int NDIG = NDIG_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [3:0] widx,
   input  logic [3:0] wdata,
   input  logic [3:0] ridx,
   output logic [3:0] rdata
);

   logic [3:0] mem [NDIG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NDIG; i++) begin
            mem[i] <= 4'h0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/grey_scan_ctrl.sv
// grey_scan_ctrl: scans the counter's digit mux into a snapshot, then streams it MS-first.
// Define GREY_SCAN_LZB_EN to blank leading zeros with 4'hF.
module grey_scan_ctrl
   import grey_scan_pkg::*;
#(
   parameter int NDIG   = NDIG_DEF,
   parameter int SETTLE = SETTLE_DEF,
   parameter int SELW   = SELW_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_req,
   input  logic [7:0]      i_cnt,
   output logic [SELW-1:0] o_sel,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err,
   grey_scan_if.master     st
);

   state_t     state;
   state_t     state_n;
   logic [3:0] idx;
   logic [3:0] pos;
   logic [3:0] rdata;
   logic [7:0] scnt;
   logic       start;
   logic       cap;
   logic       hs;
   logic       blank;

   assign hs = st.o_valid & st.i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      cap     = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_req) begin
               start   = 1'b1;
               state_n = SEL;
            end
         end
         SEL: begin
            if (scnt == 8'd1) begin
               state_n = CAP;
            end
         end
         CAP: begin
            cap     = 1'b1;
            state_n = (idx == 4'h0) ? OUT : SEL;
         end
         OUT: begin
            if (hs && pos == 4'h0) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx   <= 4'h0;
         pos   <= 4'h0;
         scnt  <= 8'h0;
         o_err <= 1'b0;
      end else begin
         if (start) begin
            idx   <= 4'(NDIG - 1);
            scnt  <= 8'(SETTLE);
            o_err <= 1'b0;
         end
         if (state == SEL) begin
            scnt <= scnt - 8'd1;
         end
         if (cap) begin
            o_err <= o_err | bad_digit(i_cnt);
            if (idx != 4'h0) begin
               idx  <= idx - 4'd1;
               scnt <= 8'(SETTLE);
            end else begin
               pos <= 4'(NDIG - 1);
            end
         end
         if (hs && pos != 4'h0) begin
            pos <= pos - 4'd1;
         end
      end
   end

   grey_scan_buf #(
      .NDIG (NDIG)
   ) u_buf (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .we    (cap),
      .widx  (idx),
      .wdata (i_cnt[3:0]),
      .ridx  (pos),
      .rdata (rdata)
   );

`ifdef GREY_SCAN_LZB_EN
   logic seen;

   // Cleared on the CAP->OUT edge so every frame starts blanking afresh.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seen <= 1'b0;
      end else if (cap && idx == 4'h0) begin
         seen <= 1'b0;
      end else if (hs && rdata != 4'h0) begin
         seen <= 1'b1;
      end
   end

   assign blank = !seen && rdata == 4'h0 && pos != 4'h0;
`else
   assign blank = 1'b0;
`endif

   // idx rests at 0 outside the burst, which keeps the select parked at 0.
   assign o_sel      = SELW'(idx);
   assign o_busy     = state != IDLE;
   assign o_done     = state == DONE;
   assign st.o_valid = state == OUT;
   assign st.o_pos   = st.o_valid ? pos : 4'h0;
   assign st.o_digit = !st.o_valid ? 4'h0 :
                       blank       ? BLANK : rdata;

endmodule

// File: tb/tb_grey_scan_ctrl.sv
// tb_grey_scan_ctrl: table vectors, reset corner cases and random frames
// against a digit-list reference model of the scan sequencer.
module tb_grey_scan_ctrl;

   localparam int NDIG   = 12;
   localparam int SETTLE = 2;
   localparam int SELW   = 6;

`ifdef GREY_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct {
      logic [47:0] cnt;
      logic [47:0] raw;
      logic [47:0] lzb;
      logic [3:0]  hidx;
      bit          err;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req = 1'b0;
   logic [7:0]      cnt;
   logic [SELW-1:0] sel;
   logic            busy;
   logic            done;
   logic            err;
   logic [3:0]      dig [NDIG];
   logic [3:0]      hi  [NDIG];
   int              n_chk = 0;
   int              n_pass = 0;
   int              done_cnt = 0;
   vec_t            vt [7];

   grey_scan_if st ();

   grey_scan_ctrl #(
      .NDIG   (NDIG),
      .SETTLE (SETTLE),
      .SELW   (SELW)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_cnt   (cnt),
      .o_sel   (sel),
      .o_busy  (busy),
      .o_done  (done),
      .o_err   (err),
      .st      (st)
   );

   always #5 clk = ~clk;

   // Counter model: the digit mux answers whatever the select points at.
   always_comb begin
      cnt = 8'h00;
      if (int'(sel) < NDIG) begin
         cnt = {hi[sel[3:0]], dig[sel[3:0]]};
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [47:0] v);
      for (int i = 0; i < NDIG; i++) begin
         dig[i] = v[4*i +: 4];
         hi[i]  = 4'h0;
      end
   endtask

   function automatic logic [47:0] model_stream();
      logic [47:0] r;
      bit          seen;
      r    = '0;
      seen = 1'b0;
      for (int p = NDIG - 1; p >= 0; p--) begin
         if (LZB && !seen && dig[p] == 4'h0 && p != 0) r[4*p +: 4] = 4'hF;
         else r[4*p +: 4] = dig[p];
         if (dig[p] != 4'h0) seen = 1'b1;
      end
      return r;
   endfunction

   function automatic bit model_err();
      bit e;
      e = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig[i] > 4'd9 || hi[i] != 4'h0) e = 1'b1;
      end
      return e;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, " sel"}, 64'(sel), 0);
      chk({tag, " busy"}, 64'(busy), 0);
      chk({tag, " valid"}, 64'(st.o_valid), 0);
      chk({tag, " digit"}, 64'(st.o_digit), 0);
      chk({tag, " pos"}, 64'(st.o_pos), 0);
      chk({tag, " done"}, 64'(done), 0);
      chk({tag, " err"}, 64'(err), 0);
   endtask

   // One request -> burst -> stream -> done, checked cycle by cycle.
   task automatic run_frame(input logic [47:0] exp_s, input bit exp_err,
                            input int rmode, input bit mutate,
                            input bit poke, input string tag);
      int base;
      int k;
      int cyc;
      bit rdy;
      base = done_cnt;
      @(negedge clk);
      req = 1'b1;
      st.i_ready = 1'b0;
      @(negedge clk);
      req = 1'b0;
      chk({tag, " busy start"}, 64'(busy), 1);
      chk({tag, " err cleared"}, 64'(err), 0);
      for (int j = 0; j < NDIG * (SETTLE + 1); j++) begin
         chk($sformatf("%s sel j%0d", tag, j), 64'(sel),
             64'(NDIG - 1 - j / (SETTLE + 1)));
         chk($sformatf("%s burst valid j%0d", tag, j), 64'(st.o_valid), 0);
         @(negedge clk);
      end
      k   = 0;
      cyc = 0;
      while (k < NDIG && cyc < 300) begin
         chk($sformatf("%s valid k%0d", tag, k), 64'(st.o_valid), 1);
         chk($sformatf("%s pos k%0d", tag, k), 64'(st.o_pos), 64'(NDIG - 1 - k));
         chk($sformatf("%s digit k%0d", tag, k), 64'(st.o_digit),
             64'(exp_s[4*(NDIG-1-k) +: 4]));
         chk($sformatf("%s err k%0d", tag, k), 64'(err), 64'(exp_err));
         if (rmode == 0) rdy = 1'b1;
         else if (rmode == 1) rdy = (cyc % 3 == 0);
         else rdy = 1'($urandom % 2);
         st.i_ready = rdy;
         if (poke) req = 1'($urandom % 2);
         if (mutate) begin
            for (int i = 0; i < NDIG; i++) dig[i] = 4'($urandom % 10);
         end
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      req = 1'b0;
      st.i_ready = 1'b0;
      chk({tag, " accepted"}, 64'(k), 64'(NDIG));
      chk({tag, " done pulse"}, 64'(done), 1);
      chk({tag, " done valid"}, 64'(st.o_valid), 0);
      @(negedge clk);
      chk({tag, " done low"}, 64'(done), 0);
      chk({tag, " idle busy"}, 64'(busy), 0);
      chk({tag, " idle sel"}, 64'(sel), 0);
      chk({tag, " err sticky"}, 64'(err), 64'(exp_err));
      chk({tag, " done count"}, 64'(done_cnt), 64'(base + 1));
   endtask

   task automatic reset_mid(input int ncyc, input string tag);
      int base;
      load(48'h123456789012);
      hi[11] = 4'h1;
      st.i_ready = 1'b1;
      base = done_cnt;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (ncyc) @(negedge clk);
      chk({tag, " err before rst"}, 64'(err), 1);
      chk({tag, " busy before rst"}, 64'(busy), 1);
      #1 rst_n = 1'b0;
      #1 chk_zero({tag, " async rst"});
      @(negedge clk);
      rst_n = 1'b1;
      st.i_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, " busy after rst"}, 64'(busy), 0);
      chk({tag, " no done"}, 64'(done_cnt), 64'(base));
      load(48'h000000123456);
      run_frame(LZB ? 48'hFFFFFF123456 : 48'h000000123456, 1'b0, 0, 1'b0,
                1'b0, {tag, " refill"});
   endtask

   initial begin
      vt[0] = '{48'h000000123456, 48'h000000123456, 48'hFFFFFF123456, 4'hF, 1'b0};
      vt[1] = '{48'h000000000000, 48'h000000000000, 48'hFFFFFFFFFFF0, 4'hF, 1'b0};
      vt[2] = '{48'h000000C00000, 48'h000000C00000, 48'hFFFFFFC00000, 4'hF, 1'b1};
      vt[3] = '{48'h987654321098, 48'h987654321098, 48'h987654321098, 4'hF, 1'b0};
      vt[4] = '{48'h000305000900, 48'h000305000900, 48'hFFF305000900, 4'hF, 1'b0};
      vt[5] = '{48'h000000000007, 48'h000000000007, 48'hFFFFFFFFFFF7, 4'hF, 1'b0};
      vt[6] = '{48'h100000000000, 48'h100000000000, 48'h100000000000, 4'd4, 1'b1};

      st.i_ready = 1'b0;
      load(48'h0);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load(vt[i].cnt);
         if (vt[i].hidx != 4'hF) hi[vt[i].hidx] = 4'h3;
         run_frame(LZB ? vt[i].lzb : vt[i].raw, vt[i].err, i % 3,
                   1'(i % 2), (i % 2) == 0, $sformatf("vec%0d", i));
      end

      reset_mid(10, "rst burst");
      reset_mid(40, "rst stream");

      for (int n = 0; n < 25; n++) begin
         int nlead;
         nlead = int'($urandom % 13);
         for (int i = 0; i < NDIG; i++) begin
            dig[i] = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom % 10);
            hi[i]  = 4'h0;
            if (i >= NDIG - nlead) dig[i] = 4'h0;
         end
         if ($urandom % 5 == 0) dig[$urandom % NDIG] = 4'(10 + $urandom % 6);
         if ($urandom % 7 == 0) hi[$urandom % NDIG] = 4'(1 + $urandom % 15);
         run_frame(model_stream(), model_err(), n % 3, 1'($urandom % 2),
                   1'($urandom % 2), $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
